// File: rtl/funct_generator_sequencer.sv
// funct_generator_sequencer: burst command controller for funct_generator.
// Configures, runs, pauses and counts generator samples; reports done/error.
module funct_generator_sequencer #(
    parameter int INT_BITS    = 4,
    parameter int LEN_WIDTH   = 16,
    parameter int CONF_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_sel_i,
    input  logic [INT_BITS-1:0]  cmd_amp_i,
    input  logic [LEN_WIDTH-1:0] cmd_len_i,
    input  logic                 abort_i,
    input  logic                 fifo_afull_i,
    input  logic                 gen_wr_en_i,
    output logic                 gen_en_low_o,
    output logic                 gen_conf_o,
    output logic [INT_BITS-1:0]  gen_amp_o,
    output logic [1:0]           gen_sel_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [LEN_WIDTH-1:0] sample_cnt_o
);

    localparam int CW = (CONF_CYCLES > 1) ? $clog2(CONF_CYCLES) : 1;
    localparam logic [CW-1:0] CONF_LAST = CW'(CONF_CYCLES - 1);
    localparam logic [INT_BITS-1:0] AMP_MIN = {1'b1, {(INT_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_conf_cnt;
    logic [CW-1:0]        w_conf_cnt_nxt;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] w_len_nxt;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [LEN_WIDTH-1:0] w_cnt_nxt;
    logic [INT_BITS-1:0]  r_amp;
    logic [INT_BITS-1:0]  w_amp_nxt;
    logic [1:0]           r_sel;
    logic [1:0]           w_sel_nxt;
    logic                 w_err_nxt;

    logic                 r_ready;
    logic                 r_en_low;
    logic                 r_conf;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_amp_bad;
    logic                 w_counting;
    logic                 w_last;
    logic [LEN_WIDTH-1:0] w_len_m1;

    assign w_accept   = cmd_valid_i && r_ready;
    assign w_amp_bad  = (cmd_amp_i == '0) || (cmd_amp_i == AMP_MIN);
    assign w_counting = gen_wr_en_i &&
                        ((r_state == S_RUN) || (r_state == S_PAUSE));
    assign w_len_m1   = r_len - LEN_WIDTH'(1);
    assign w_last     = w_counting && (r_cnt == w_len_m1);

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_conf_cnt <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_amp      <= INT_BITS'(1);
            r_sel      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_conf_cnt <= w_conf_cnt_nxt;
            r_len      <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            r_amp      <= w_amp_nxt;
            r_sel      <= w_sel_nxt;
        end
    end

    // Next-state, command latch and saturating sample counter
    always_comb begin
        w_state_nxt    = r_state;
        w_conf_cnt_nxt = r_conf_cnt;
        w_len_nxt      = r_len;
        w_cnt_nxt      = r_cnt;
        w_amp_nxt      = r_amp;
        w_sel_nxt      = r_sel;
        w_err_nxt      = 1'b0;

        // an abort freezes the count at its current value
        if (w_counting && !abort_i && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + LEN_WIDTH'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_amp_nxt = cmd_amp_i;
                    w_sel_nxt = cmd_sel_i;
                    w_len_nxt = cmd_len_i;
                    w_cnt_nxt = '0;
                    if (w_amp_bad) begin
                        w_err_nxt = 1'b1;
                    end else if (cmd_len_i == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt    = S_CONFIG;
                        w_conf_cnt_nxt = '0;
                    end
                end
            end
            S_CONFIG: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (r_conf_cnt == CONF_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_conf_cnt_nxt = r_conf_cnt + CW'(1);
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end else if (fifo_afull_i) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end else if (!fifo_afull_i) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs derived from the upcoming state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ready  <= 1'b1;
            r_en_low <= 1'b1;
            r_conf   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ready  <= (w_state_nxt == S_IDLE);
            r_en_low <= (w_state_nxt != S_RUN);
            r_conf   <= (w_state_nxt == S_CONFIG);
            r_busy   <= (w_state_nxt == S_CONFIG) ||
                        (w_state_nxt == S_RUN) ||
                        (w_state_nxt == S_PAUSE);
            r_done   <= (r_state == S_DONE);
            r_err    <= w_err_nxt;
        end
    end

    assign cmd_ready_o  = r_ready;
    assign gen_en_low_o = r_en_low;
    assign gen_conf_o   = r_conf;
    assign gen_amp_o    = r_amp;
    assign gen_sel_o    = r_sel;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign sample_cnt_o = r_cnt;

endmodule
